// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code position tracker.
package gray_pkg;

    localparam int unsigned GrayW = 3;
    localparam int unsigned RevW  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StErr
    } state_e;

endpackage

// File: rtl/gray2bin.sv
// Combinational 3-bit reflected-Gray to binary converter.
module gray2bin
    import gray_pkg::*;
(
    input  logic [GrayW-1:0] gray_i,
    output logic [GrayW-1:0] bin_o
);

    always_comb begin
        bin_o[2] = gray_i[2];
        bin_o[1] = gray_i[2] ^ gray_i[1];
        bin_o[0] = gray_i[2] ^ gray_i[1] ^ gray_i[0];
    end

endmodule

// File: rtl/gray_pos_tracker.sv
// Tracks a 3-bit Gray-coded sensor into a signed position with illegal-jump detection.
// Optional revolution counter enabled by defining GRAY_REV_CNT_EN.
module gray_pos_tracker
    import gray_pkg::*;
#(
    parameter int unsigned POS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [GrayW-1:0] in_gray,
    output logic             in_ready,
    input  logic             clr_err,
    output logic [GrayW-1:0] bin,
    output logic [POS_W-1:0] pos,
    output logic             step,
    output logic             dir,
`ifdef GRAY_REV_CNT_EN
    output logic             err,
    output logic [RevW-1:0]  rev
`else
    output logic             err
`endif
);

    state_e             state_q, state_d;
    logic [GrayW-1:0]   bin_q, bin_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    logic [GrayW-1:0]   new_bin;
    logic [GrayW-1:0]   delta;
    logic               xfer;
`ifdef GRAY_REV_CNT_EN
    logic [RevW-1:0]    rev_q, rev_d;
`endif

    gray2bin u_gray2bin (
        .gray_i (in_gray),
        .bin_o  (new_bin)
    );

    assign in_ready = (state_q != StErr);
    assign xfer     = in_valid && in_ready;
    // Modulo-8 distance from the reference code; 1 and 7 are the only legal moves.
    assign delta    = new_bin - bin_q;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
`ifdef GRAY_REV_CNT_EN
        rev_d   = rev_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    bin_d   = new_bin;
                    state_d = StTrack;
                end
            end
            StTrack: begin
                if (xfer) begin
                    case (delta)
                        3'd0: ;
                        3'd1: begin
                            pos_d  = pos_q + 1'b1;
                            dir_d  = 1'b1;
                            step_d = 1'b1;
                            bin_d  = new_bin;
`ifdef GRAY_REV_CNT_EN
                            if (bin_q == 3'd7) rev_d = rev_q + 1'b1;
`endif
                        end
                        3'd7: begin
                            pos_d  = pos_q - 1'b1;
                            dir_d  = 1'b0;
                            step_d = 1'b1;
                            bin_d  = new_bin;
`ifdef GRAY_REV_CNT_EN
                            if (bin_q == 3'd0) rev_d = rev_q - 1'b1;
`endif
                        end
                        default: state_d = StErr;
                    endcase
                end
            end
            StErr: begin
                if (clr_err) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            bin_q   <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
`ifdef GRAY_REV_CNT_EN
            rev_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
`ifdef GRAY_REV_CNT_EN
            rev_q   <= rev_d;
`endif
        end
    end

    assign bin  = bin_q;
    assign pos  = pos_q;
    assign step = step_q;
    assign dir  = dir_q;
    assign err  = (state_q == StErr);
`ifdef GRAY_REV_CNT_EN
    assign rev  = rev_q;
`endif

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Self-checking bench for gray_pos_tracker: directed vector table, a full-turn walk,
// and randomized traffic against a behavioural model.
module tb_gray_pos_tracker;

    localparam int unsigned POS_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [2:0]       in_gray = 3'b000;
    logic             clr_err = 1'b0;
    logic             in_ready;
    logic [2:0]       bin;
    logic [POS_W-1:0] pos;
    logic             step;
    logic             dir;
    logic             err;
`ifdef GRAY_REV_CNT_EN
    logic [3:0]       rev;
`endif

    gray_pos_tracker #(.POS_W(POS_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_gray  (in_gray),
        .in_ready (in_ready),
        .clr_err  (clr_err),
        .bin      (bin),
        .pos      (pos),
        .step     (step),
        .dir      (dir),
`ifdef GRAY_REV_CNT_EN
        .err      (err),
        .rev      (rev)
`else
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Gray sequence: position index i has code gtab[i].
    logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    // Behavioural model state
    bit m_ref;
    bit m_err;
    int m_cur;
    int m_pos;
    bit m_step;
    bit m_dir;
    int m_rev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int gray_index(input logic [2:0] g);
        for (int i = 0; i < 8; i++) if (gtab[i] == g) return i;
        return 0;
    endfunction

    task automatic model_update(input bit r, input bit v, input logic [2:0] g, input bit c);
        int nb;
        int d;
        m_step = 0;
        if (r) begin
            m_ref = 0; m_err = 0; m_cur = 0; m_pos = 0; m_dir = 0; m_rev = 0;
        end else if (m_err) begin
            if (c) begin
                m_err = 0;
                m_ref = 0;
            end
        end else if (v) begin
            nb = gray_index(g);
            if (!m_ref) begin
                m_cur = nb;
                m_ref = 1;
            end else begin
                d = (nb - m_cur + 8) % 8;
                if (d == 1) begin
                    if (m_cur == 7) m_rev = (m_rev + 1) % 16;
                    m_pos = (m_pos + 1) % (1 << POS_W);
                    m_dir = 1; m_step = 1; m_cur = nb;
                end else if (d == 7) begin
                    if (m_cur == 0) m_rev = (m_rev + 15) % 16;
                    m_pos = (m_pos + (1 << POS_W) - 1) % (1 << POS_W);
                    m_dir = 0; m_step = 1; m_cur = nb;
                end else if (d != 0) begin
                    m_err = 1;
                end
            end
        end
    endtask

    // Drive one cycle, advance the model, and compare every output against it.
    task automatic cycle_model(input string tag, input bit r, input bit v, input logic [2:0] g,
                               input bit c);
        rst = r; in_valid = v; in_gray = g; clr_err = c;
        @(posedge clk);
        #1;
        model_update(r, v, g, c);
        check({tag, ".bin"},   {29'd0, bin},  m_cur);
        check({tag, ".pos"},   {24'd0, pos},  m_pos);
        check({tag, ".step"},  {31'd0, step}, {31'd0, m_step});
        check({tag, ".dir"},   {31'd0, dir},  {31'd0, m_dir});
        check({tag, ".err"},   {31'd0, err},  {31'd0, m_err});
        check({tag, ".rdy"},   {31'd0, in_ready}, {31'd0, !m_err});
`ifdef GRAY_REV_CNT_EN
        check({tag, ".rev"},   {28'd0, rev},  m_rev);
`endif
    endtask

    typedef struct {
        bit         r;
        bit         v;
        logic [2:0] g;
        bit         c;
        logic [2:0] e_bin;
        logic [7:0] e_pos;
        bit         e_step;
        bit         e_dir;
        bit         e_err;
        bit         e_rdy;
    } vec_t;

    localparam int NVec = 24;
    vec_t vecs [NVec];

    initial begin
        //           r  v  g       c  bin pos    st dir err rdy
        vecs[0]  = '{1, 0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 1};  // reset
        vecs[1]  = '{0, 1, 3'b000, 0, 0, 8'h00, 0, 0, 0, 1};  // IDLE load
        vecs[2]  = '{0, 1, 3'b001, 0, 1, 8'h01, 1, 1, 0, 1};
        vecs[3]  = '{0, 1, 3'b011, 0, 2, 8'h02, 1, 1, 0, 1};
        vecs[4]  = '{0, 1, 3'b010, 0, 3, 8'h03, 1, 1, 0, 1};
        vecs[5]  = '{0, 1, 3'b010, 0, 3, 8'h03, 0, 1, 0, 1};  // same code
        vecs[6]  = '{0, 0, 3'b110, 0, 3, 8'h03, 0, 1, 0, 1};  // no valid
        vecs[7]  = '{1, 1, 3'b001, 0, 0, 8'h00, 0, 0, 0, 1};  // reset beats transfer
        vecs[8]  = '{0, 1, 3'b000, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[9]  = '{0, 1, 3'b100, 0, 7, 8'hFF, 1, 0, 0, 1};
        vecs[10] = '{0, 1, 3'b101, 0, 6, 8'hFE, 1, 0, 0, 1};
        vecs[11] = '{1, 0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[12] = '{0, 1, 3'b000, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[13] = '{0, 1, 3'b001, 0, 1, 8'h01, 1, 1, 0, 1};
        vecs[14] = '{0, 1, 3'b110, 0, 1, 8'h01, 0, 1, 1, 0};  // illegal jump
        vecs[15] = '{0, 1, 3'b000, 0, 1, 8'h01, 0, 1, 1, 0};  // blocked in ERR
        vecs[16] = '{0, 1, 3'b001, 1, 1, 8'h01, 0, 1, 0, 1};  // clear wins
        vecs[17] = '{0, 1, 3'b011, 0, 2, 8'h01, 0, 1, 0, 1};  // back in IDLE: load only
        vecs[18] = '{0, 1, 3'b010, 0, 3, 8'h02, 1, 1, 0, 1};
        vecs[19] = '{0, 0, 3'b010, 1, 3, 8'h02, 0, 1, 0, 1};  // clr ignored in TRACK
        vecs[20] = '{1, 1, 3'b110, 0, 0, 8'h00, 0, 0, 0, 1};  // reset mid-run
        vecs[21] = '{0, 1, 3'b000, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[22] = '{0, 1, 3'b100, 0, 7, 8'hFF, 1, 0, 0, 1};
        vecs[23] = '{0, 1, 3'b000, 0, 0, 8'h00, 1, 1, 0, 1};  // 0xFF + 1 wraps

        @(posedge clk);
        #1;
        for (int i = 0; i < NVec; i++) begin
            rst = vecs[i].r; in_valid = vecs[i].v; in_gray = vecs[i].g; clr_err = vecs[i].c;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.bin", i),  {29'd0, bin},      {29'd0, vecs[i].e_bin});
            check($sformatf("vec%0d.pos", i),  {24'd0, pos},      {24'd0, vecs[i].e_pos});
            check($sformatf("vec%0d.step", i), {31'd0, step},     {31'd0, vecs[i].e_step});
            check($sformatf("vec%0d.dir", i),  {31'd0, dir},      {31'd0, vecs[i].e_dir});
            check($sformatf("vec%0d.err", i),  {31'd0, err},      {31'd0, vecs[i].e_err});
            check($sformatf("vec%0d.rdy", i),  {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
        end

        // Full turn up from 0 back to 0, then one step down across zero.
        cycle_model("walk_rst", 1'b1, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i <= 8; i++) cycle_model($sformatf("walk%0d", i), 1'b0, 1'b1, gtab[i % 8], 1'b0);
        check("walk_pos", {24'd0, pos}, 32'd8);
`ifdef GRAY_REV_CNT_EN
        check("walk_rev", {28'd0, rev}, 32'd1);
`endif
        cycle_model("walk_down", 1'b0, 1'b1, gtab[7], 1'b0);
`ifdef GRAY_REV_CNT_EN
        check("walk_rev_down", {28'd0, rev}, 32'd0);
`endif

        // Randomized traffic, biased toward legal single steps.
        for (int n = 0; n < 600; n++) begin
            bit         r, v, c;
            int         k, idx;
            logic [2:0] g;
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 5) == 0);
            k = $urandom_range(0, 19);
            if (k < 8)       idx = (m_cur + 1) % 8;
            else if (k < 16) idx = (m_cur + 7) % 8;
            else if (k < 18) idx = m_cur;
            else             idx = $urandom_range(0, 7);
            g = gtab[idx];
            cycle_model($sformatf("rnd%0d", n), r, v, g, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_pos_tracker.md
GRAY_POS_TRACKER -- requirements
Module: gray_pos_tracker

Interface
REQ-001 Parameter: POS_W, default 8, width of position counter.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_gray holds a code to be consumed.
REQ-005 in_gray  input  3  3-bit reflected Gray code (0..7 = 000,001,011,010,110,111,101,100).
REQ-006 in_ready  output  1  block accepts in_gray this cycle.
REQ-007 clr_err  input  1  clears error state.
REQ-008 bin  output  3  binary value of last accepted code.
REQ-009 pos  output  POS_W  accumulated position, two's complement.
REQ-010 step  output  1  one-cycle pulse per counted step.
REQ-011 dir  output  1  direction of last counted step, 1 = up.
REQ-012 err  output  1  illegal transition detected, level.
REQ-013 rev  output  4  signed revolution count; present only with GRAY_REV_CNT_EN.

Function
REQ-014 Transfer SHALL occur on a rising clk edge with in_valid && in_ready; no transfer otherwise.
REQ-015 in_ready SHALL be 1 in IDLE and TRACK, 0 in ERR.
REQ-016 States SHALL be IDLE (no reference code), TRACK, ERR.
REQ-017 IDLE: transfer loads bin with the decoded code, no step, pos unchanged, next state TRACK.
REQ-018 TRACK: d = (new_bin - bin) mod 8 SHALL be computed on each transfer.
REQ-019 d = 0: no step, no change to any output except step = 0.
REQ-020 d = 1: pos += 1, dir = 1, step = 1, bin = new_bin.
REQ-021 d = 7: pos -= 1, dir = 0, step = 1, bin = new_bin.
REQ-022 d in 2..6: err = 1, next state ERR; pos, bin, dir held; step = 0.
REQ-023 pos SHALL wrap modulo 2^POS_W in both directions (max + 1 -> 0, 0 - 1 -> all ones).
REQ-024 All outputs SHALL be registered; effect of a transfer visible the cycle after the accepting edge (latency 1).
REQ-025 step SHALL be high for exactly one cycle per counted transfer; back-to-back transfers give back-to-back pulses.
REQ-026 ERR: clr_err = 1 SHALL clear err and move to IDLE on the next edge; pos and bin retained.
REQ-027 clr_err SHALL be ignored in IDLE and TRACK.
REQ-028 clr_err and in_valid both high in ERR: only clear takes effect (in_ready = 0, no transfer).

Reset
REQ-029 rst SHALL override all other inputs on the edge it is sampled high.
REQ-030 Reset values: state IDLE, bin = 0, pos = 0, step = 0, dir = 0, err = 0, rev = 0; in_ready = 1 the cycle after reset.
REQ-031 Reset mid-operation (any state, any pending transfer) SHALL discard the transfer and return to reset values.

Configuration
REQ-032 Macro GRAY_REV_CNT_EN defined: rev port and logic present; rev += 1 on counted up step with bin 7 -> 0, rev -= 1 on counted down step with bin 0 -> 7, wraps modulo 16.
REQ-033 GRAY_REV_CNT_EN undefined: rev port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-034 Shared package gray_pkg SHALL hold the state encoding (IDLE, TRACK, ERR) and the Gray code width constant 3.
REQ-035 Gray-to-binary conversion SHALL be a combinational sub-module gray2bin (3-bit in, 3-bit out), instantiated once on in_gray.
REQ-036 Implementation target: 120-400 lines of RTL total.

Verification
REQ-037 Reset, then in_gray 000, then 001, 011, 010 with in_valid each cycle -> bin 3, pos 3, dir 1, step high 3 consecutive cycles after the first.
REQ-038 From bin 0, codes 100, 101 -> pos 0xFE (POS_W 8), dir 0; with GRAY_REV_CNT_EN rev = 4'hF.
REQ-039 From bin 1 (001), in_gray 110 (4) -> err = 1, in_ready = 0, pos/bin unchanged; clr_err + in_valid same cycle -> next cycle err 0, state IDLE, no transfer.
REQ-040 pos at 0xFF, up step -> pos 0x00; walk 0..7..0 up with GRAY_REV_CNT_EN -> rev = 1.
REQ-041 Same code repeated (011 twice) -> no step, pos unchanged; rst asserted mid-sequence -> all outputs at reset values next cycle.
